crc16_serial_encoder: RTL

- Serial CRC-16 transmitter. Takes a message one bit per clock, forwards it, then appends 16 CRC bits MSB-first. The result is a systematic codeword that the team's serial CRC checker validates with a zero remainder.
- Sits at the transmit end of the serial link, feeding the checker's `start`/`data` inputs directly.
- Default framing is 32 message bits + 16 CRC bits = 48-bit codeword.

---
 rtl/crc16_serial_encoder.sv | 100 ++++++++++
 1 files changed

// File: rtl/crc16_serial_encoder.sv
// Serial CRC-16 transmitter: forwards MSG_LEN message bits, then appends the 16-bit remainder MSB-first.
// Build option CRC16_INIT_ONES_EN: preload the shift register with 16'hFFFF instead of 16'h0000.
module crc16_serial_encoder #(
  parameter int unsigned MSG_LEN = 32,
  parameter logic [15:0] POLY    = 16'h1021
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic        data,
  output logic        dout,
  output logic        dout_valid,
  output logic        busy,
  output logic        done,
  output logic [15:0] crc
);

`ifdef CRC16_INIT_ONES_EN
  localparam logic [15:0] INIT = 16'hFFFF;
`else
  localparam logic [15:0] INIT = 16'h0000;
`endif

  // The same counter later walks the 16 CRC bits, so it never gets narrower than 4 bits.
  localparam int CW_MSG = $clog2(MSG_LEN + 1);
  localparam int CW     = (CW_MSG < 4) ? 4 : CW_MSG;
  localparam logic [CW-1:0] MSG_LAST = CW'(MSG_LEN - 1);
  localparam logic [CW-1:0] CRC_LAST = CW'(15);

  typedef enum logic [1:0] {S_IDLE, S_MSG, S_CRC, S_DONE} state_t;

  state_t        state;
  logic [15:0]   sr;
  logic [15:0]   hold;
  logic [CW-1:0] cnt;
  logic          fb;
  logic [15:0]   sr_msg;

  assign fb     = data ^ sr[15];
  assign sr_msg = {sr[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= S_IDLE;
      sr         <= INIT;
      hold       <= 16'h0000;
      cnt        <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      crc        <= 16'h0000;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          dout       <= 1'b0;
          dout_valid <= 1'b0;
          busy       <= 1'b0;
          // busy is still high in the done cycle, which keeps a start there from launching a frame.
          if (start && !busy) begin
            sr    <= INIT;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_MSG;
          end
        end
        S_MSG: begin
          sr         <= sr_msg;
          dout       <= data;
          dout_valid <= 1'b1;
          if (cnt == MSG_LAST) begin
            cnt   <= '0;
            hold  <= sr_msg;
            state <= S_CRC;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_CRC: begin
          dout       <= sr[15];
          sr         <= {sr[14:0], 1'b0};
          dout_valid <= 1'b1;
          if (cnt == CRC_LAST) state <= S_DONE;
          else                 cnt   <= cnt + CW'(1);
        end
        S_DONE: begin
          dout       <= 1'b0;
          dout_valid <= 1'b0;
          busy       <= 1'b1;
          done       <= 1'b1;
          crc        <= hold;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
